// File: rtl/local_history_table_if.sv
// Bus bundle for the local history table: lookup request/response,
// resolved-branch update, flush pulse and busy status.
// Widths track the PC and history widths of the attached table.
interface local_history_table_if #(
  parameter int PC_BITS   = 32,
  parameter int HIST_BITS = 10
);
  logic                 lookup_valid;
  logic [PC_BITS-1:0]   lookup_pc;
  logic                 lookup_ready;
  logic                 hist_valid;
  logic [HIST_BITS-1:0] hist_out;
  logic                 update_valid;
  logic [PC_BITS-1:0]   update_pc;
  logic                 update_taken;
  logic                 flush;
  logic                 busy;

  // Requester side: issues lookups, updates and flushes.
  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_taken, flush,
    input  lookup_ready, hist_valid, hist_out, busy
  );

  // Table side.
  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken, flush,
    output lookup_ready, hist_valid, hist_out, busy
  );
endinterface

// File: rtl/local_history_table.sv
// Local history table: one shift register of recent outcomes per entry,
// indexed by pc[INDEX_BITS+1:2]. A registered lookup returns the history
// that indexes the local counter table; resolved outcomes shift in as LSB.
// A sequenced sweep zeroes every entry after reset or a flush pulse.
// Optional feature macro: LHT_BYPASS_EN -- a same-cycle lookup and update to
// the same entry returns the post-update history instead of the stored one.
module local_history_table #(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 10,
  parameter int HIST_BITS  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  local_history_table_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [INDEX_BITS-1:0] r_clr_idx;
  logic [INDEX_BITS-1:0] w_next_clr_idx;

  // NOTE: the history array has no reset branch; zeroing it in one cycle would
  // force every entry into flops with a wide reset fan-out, so the sweep does it.
  logic [HIST_BITS-1:0]  r_hist_mem [ENTRIES];

  logic                  r_hist_valid;
  logic [HIST_BITS-1:0]  r_hist_out;

  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic [INDEX_BITS-1:0] w_update_idx;
  logic                  w_lookup_accept;
  logic                  w_update_en;
  logic [HIST_BITS-1:0]  w_update_entry;
  logic [HIST_BITS-1:0]  w_update_shifted;
  logic [HIST_BITS-1:0]  w_lookup_data;
  logic                  w_unused_pc;

  // Word-aligned index; PC bits above the index alias onto the same entry.
  assign w_lookup_idx = bus.lookup_pc[INDEX_BITS+1:2];
  assign w_update_idx = bus.update_pc[INDEX_BITS+1:2];
  assign w_unused_pc  = ^{bus.lookup_pc, bus.update_pc};

  // Lookups are accepted only in RUN, including a cycle that carries a flush.
  assign w_lookup_accept = bus.lookup_valid && (r_state == ST_RUN);

  // Updates are dropped during the sweep, on a flush cycle and under reset.
  assign w_update_en = bus.update_valid && (r_state == ST_RUN) && !bus.flush && !reset;

  // Newest outcome enters at the LSB; the oldest bit falls off the top.
  assign w_update_entry   = r_hist_mem[w_update_idx];
  assign w_update_shifted = {w_update_entry[HIST_BITS-2:0], bus.update_taken};

  // State register for the clear/run sequencer; reset restarts the sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_idx <= w_next_clr_idx;
    end
  end

  // Next-state logic: sweep every index once, restart on flush, then run.
  // NOTE: defaults are assigned first so every path drives both outputs and
  // no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_next_clr_idx = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        if (bus.flush) begin
          w_next_clr_idx = '0;
        end else if (&r_clr_idx) begin
          w_next_state   = ST_RUN;
          w_next_clr_idx = '0;
        end else begin
          w_next_clr_idx = r_clr_idx + INDEX_BITS'(1);
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          w_next_state   = ST_CLEAR;
          w_next_clr_idx = '0;
        end
      end
      default: begin
        w_next_state   = ST_CLEAR;
        w_next_clr_idx = '0;
      end
    endcase
  end

  // Lookup data source: stored history, or the freshly shifted value when a
  // same-entry update lands in the same cycle and bypass is enabled.
  always_comb begin
    w_lookup_data = r_hist_mem[w_lookup_idx];
`ifdef LHT_BYPASS_EN
    if (w_update_en && (w_update_idx == w_lookup_idx)) begin
      w_lookup_data = w_update_shifted;
    end
`endif
  end

  // History array write port: sweep zeroes one entry per cycle, else update.
  always_ff @(posedge clock) begin
    if (r_state == ST_CLEAR) begin
      r_hist_mem[r_clr_idx] <= '0;
    end else if (w_update_en) begin
      r_hist_mem[w_update_idx] <= w_update_shifted;
    end
  end

  // Registered lookup response; hist_out holds when no lookup was accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist_valid <= 1'b0;
      r_hist_out   <= '0;
    end else begin
      r_hist_valid <= w_lookup_accept;
      if (w_lookup_accept) begin
        r_hist_out <= w_lookup_data;
      end
    end
  end

  assign bus.lookup_ready = (r_state == ST_RUN);
  assign bus.busy         = (r_state == ST_CLEAR);
  assign bus.hist_valid   = r_hist_valid;
  assign bus.hist_out     = r_hist_out;

endmodule

// File: tb/tb_local_history_table.sv
// Testbench for local_history_table (INDEX_BITS=4, HIST_BITS=10).
// Directed vector table, hand-written sweep/flush sequences, then random
// traffic against an array-based reference model of the history table.
module tb_local_history_table;

  localparam int PC_BITS    = 32;
  localparam int INDEX_BITS = 4;
  localparam int HIST_BITS  = 10;
  localparam int ENTRIES    = 1 << INDEX_BITS;
  localparam int HMASK      = (1 << HIST_BITS) - 1;
`ifdef LHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  local_history_table_if #(.PC_BITS(PC_BITS), .HIST_BITS(HIST_BITS)) bus ();

  local_history_table #(
    .PC_BITS   (PC_BITS),
    .INDEX_BITS(INDEX_BITS),
    .HIST_BITS (HIST_BITS)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        fl;
    logic        exp_hv;
    logic [9:0]  exp_ho_byp;
    logic [9:0]  exp_ho_nobyp;
  } vec_t;

  vec_t vecs[13];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  int mdl[ENTRIES];
  bit in_clear;
  int clear_left;
  int last_ho;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic fl);
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.update_valid = uv;
    bus.update_pc    = upc;
    bus.update_taken = ut;
    bus.flush        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Single-cycle lookup, then compare the registered result.
  task automatic lookup_check(input string name, input logic [31:0] pc, input int exp);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    check({name, "_hv"}, bus.hist_valid, 1);
    check({name, "_ho"}, bus.hist_out, exp);
  endtask

  task automatic update(input logic [31:0] pc, input logic t);
    drive(1'b0, 32'h0, 1'b1, pc, t, 1'b0);
    step();
    idle();
  endtask

  // Walk a clear sweep, checking busy/ready every cycle; optionally inject an
  // update (dropped) and a lookup (refused) on sweep cycle inj_cycle.
  task automatic sweep_check(input string name, input int inj_cycle, input logic [31:0] inj_pc);
    for (int i = 0; i < ENTRIES; i++) begin
      check({name, "_busy"}, bus.busy, 1);
      check({name, "_ready"}, bus.lookup_ready, 0);
      if (i == inj_cycle) drive(1'b1, inj_pc, 1'b1, inj_pc, 1'b1, 1'b0);
      else idle();
      step();
      if (i == inj_cycle) check({name, "_refused_hv"}, bus.hist_valid, 0);
    end
    idle();
    check({name, "_done_ready"}, bus.lookup_ready, 1);
    check({name, "_done_busy"}, bus.busy, 0);
  endtask

  initial begin
    int li, ui, exp_ho, exp_hv;
    logic lv, uv, ut, fl;
    logic [31:0] lpc, upc;

    //            lv  lpc            uv  upc     ut  fl  hv  ho_byp  ho_nobyp
    vecs[0]  = '{1'b0, 32'h0,       1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000};
    vecs[1]  = '{1'b0, 32'h0,       1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000};
    vecs[2]  = '{1'b0, 32'h0,       1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000};
    vecs[3]  = '{1'b1, 32'h04,      1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h005, 10'h005};
    vecs[4]  = '{1'b1, 32'h08,      1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000};
    vecs[5]  = '{1'b0, 32'h0,       1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000};
    vecs[6]  = '{1'b1, 32'h08,      1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h001, 10'h001};
    vecs[7]  = '{1'b1, 32'h04,      1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 10'h00B, 10'h005};
    vecs[8]  = '{1'b1, 32'h04,      1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h00B, 10'h00B};
    vecs[9]  = '{1'b1, 32'h0C,      1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 10'h000, 10'h000};
    vecs[10] = '{1'b1, 32'h10,      1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h001, 10'h001};
    vecs[11] = '{1'b0, 32'h0,       1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 10'h001, 10'h001};
    vecs[12] = '{1'b1, 32'hFFF40047, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 10'h00B, 10'h00B};

    // ---- Reset and initial sweep ----
    idle();
    reset = 1'b1;
    step();
    check("rst_busy", bus.busy, 1);
    check("rst_ready", bus.lookup_ready, 0);
    check("rst_hv", bus.hist_valid, 0);
    check("rst_ho", bus.hist_out, 0);
    reset = 1'b0;
    sweep_check("init_sweep", 5, 32'h04);
    lookup_check("first_lookup", 32'h04, 0);
    step();
    check("idle_hv", bus.hist_valid, 0);
    check("idle_ho_hold", bus.hist_out, 0);

    // ---- Directed vector table ----
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].fl);
      step();
      check($sformatf("vec%0d_hv", i), bus.hist_valid, vecs[i].exp_hv);
      check($sformatf("vec%0d_ho", i), bus.hist_out,
            BYP ? vecs[i].exp_ho_byp : vecs[i].exp_ho_nobyp);
    end
    idle();

    // ---- Same-cycle lookup/update on an entry holding 0x003 ----
    update(32'h14, 1'b1);
    update(32'h14, 1'b1);
    drive(1'b1, 32'h14, 1'b1, 32'h14, 1'b1, 1'b0);
    step();
    idle();
    check("bypass_hv", bus.hist_valid, 1);
    check("bypass_ho", bus.hist_out, BYP ? 32'h007 : 32'h003);
    lookup_check("post_bypass", 32'h14, 32'h007);

    // ---- History saturation: 11 taken, then one not-taken ----
    for (int i = 0; i < 11; i++) update(32'h18, 1'b1);
    lookup_check("all_taken", 32'h18, 32'h3FF);
    update(32'h18, 1'b0);
    lookup_check("drop_oldest", 32'h18, 32'h3FE);

    // ---- Flush in RUN with same-cycle lookup and update ----
    drive(1'b1, 32'h14, 1'b1, 32'h1C, 1'b1, 1'b1);
    step();
    idle();
    check("flush_lookup_hv", bus.hist_valid, 1);
    check("flush_lookup_ho", bus.hist_out, 32'h007);
    sweep_check("flush_sweep", 3, 32'h04);
    lookup_check("flushed_idx1", 32'h04, 0);
    lookup_check("flushed_idx7", 32'h1C, 0);
    lookup_check("flushed_idx6", 32'h18, 0);
    lookup_check("flushed_idx5", 32'h14, 0);

    // ---- Flush during a sweep restarts it from index 0 ----
    update(32'h20, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    check("reflush_busy", bus.busy, 1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    idle();
    sweep_check("reflush_sweep", -1, 32'h0);
    lookup_check("reflushed_idx8", 32'h20, 0);

    // ---- Randomized traffic against the reference model ----
    for (int e = 0; e < ENTRIES; e++) mdl[e] = 0;
    in_clear   = 1'b0;
    clear_left = 0;
    last_ho    = 0;
    for (int c = 0; c < 800; c++) begin
      lv  = 1'($urandom_range(0, 1));
      lpc = $urandom;
      uv  = 1'($urandom_range(0, 1));
      upc = $urandom;
      ut  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 59) == 0);
      li  = int'(lpc[INDEX_BITS+1:2]);
      ui  = int'(upc[INDEX_BITS+1:2]);

      check("rnd_ready", bus.lookup_ready, !in_clear);
      check("rnd_busy", bus.busy, in_clear);

      exp_hv = 0;
      exp_ho = last_ho;
      if (!in_clear) begin
        if (lv) begin
          exp_hv = 1;
          exp_ho = mdl[li];
          if (BYP && uv && !fl && li == ui) exp_ho = ((mdl[ui] << 1) | int'(ut)) & HMASK;
        end
        if (fl) begin
          for (int e = 0; e < ENTRIES; e++) mdl[e] = 0;
          in_clear   = 1'b1;
          clear_left = ENTRIES;
        end else if (uv) begin
          mdl[ui] = ((mdl[ui] << 1) | int'(ut)) & HMASK;
        end
      end else begin
        if (fl) begin
          clear_left = ENTRIES;
        end else begin
          clear_left--;
          if (clear_left == 0) in_clear = 1'b0;
        end
      end
      last_ho = exp_ho;

      drive(lv, lpc, uv, upc, ut, fl);
      step();
      check("rnd_hv", bus.hist_valid, exp_hv);
      check("rnd_ho", bus.hist_out, exp_ho);
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
